// File: rtl/iob_ddr_init_seq.sv
// DDR bring-up sequencer: holds the memory controller in reset, waits for PLL lock and
// calibration, lets things settle, then releases the SoC core; retries a bounded number of times.
module iob_ddr_init_seq #(
    parameter int unsigned RST_HOLD_CYC = 16,
    parameter int unsigned SETTLE_CYC   = 8,
    parameter int unsigned TIMEOUT_CYC  = 1048576,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned CNT_W        = 21
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       pll_locked_i,
    input  logic       init_done_i,
    input  logic       cal_success_i,
    input  logic       cal_fail_i,
    output logic       ctrl_resetn_o,
    output logic       sys_arst_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_WAIT_CAL   = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_RUN        = 3'd4,
        ST_RETRY      = 3'd5,
        ST_FAIL       = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    // Synchronizer bit order: {cal_fail, cal_success, init_done, pll_locked}
    logic [3:0] async_in;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    logic lock_s;
    logic done_s;
    logic succ_s;
    logic cfail_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;

    logic ctrl_resetn_q, ctrl_resetn_d;
    logic sys_arst_q, sys_arst_d;
    logic ready_q, ready_d;
    logic fail_q, fail_d;

    assign async_in = {cal_fail_i, cal_success_i, init_done_i, pll_locked_i};

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
        end
    end

    assign lock_s  = sync2_q[0];
    assign done_s  = sync2_q[1];
    assign succ_s  = sync2_q[2];
    assign cfail_s = sync2_q[3];

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_RESET_HOLD: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_WAIT_CAL;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_RETRY;
                end
            end
            ST_WAIT_CAL: begin
                // A reported calibration failure wins even if success is also flagged.
                if (cfail_s || !lock_s) begin
                    state_d = ST_RETRY;
                end else if (done_s && succ_s) begin
                    state_d = ST_SETTLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_RETRY;
                end
            end
            ST_SETTLE: begin
                if (!lock_s || !done_s || !succ_s) begin
                    state_d = ST_RETRY;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s || !done_s) begin
                    state_d = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (retry_q >= RETRY_MAX) begin
                    state_d = ST_FAIL;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = ST_RESET_HOLD;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET_HOLD;
            end
        endcase
    end

    // Counter restarts on every state entry, including re-entry after a retry.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        ctrl_resetn_d = 1'b1;
        sys_arst_d    = 1'b1;
        ready_d       = 1'b0;
        fail_d        = 1'b0;
        case (state_d)
            ST_RESET_HOLD: ctrl_resetn_d = 1'b0;
            ST_RETRY:      ctrl_resetn_d = 1'b0;
            ST_FAIL: begin
                ctrl_resetn_d = 1'b0;
                fail_d        = 1'b1;
            end
            ST_RUN: begin
                sys_arst_d = 1'b0;
                ready_d    = 1'b1;
            end
            default: begin
                ctrl_resetn_d = 1'b1;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as state_q.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q       <= ST_RESET_HOLD;
            cnt_q         <= '0;
            retry_q       <= '0;
            ctrl_resetn_q <= 1'b0;
            sys_arst_q    <= 1'b1;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            ctrl_resetn_q <= ctrl_resetn_d;
            sys_arst_q    <= sys_arst_d;
            ready_q       <= ready_d;
            fail_q        <= fail_d;
        end
    end

    assign ctrl_resetn_o = ctrl_resetn_q;
    assign sys_arst_o    = sys_arst_q;
    assign ready_o       = ready_q;
    assign fail_o        = fail_q;
    assign retry_cnt_o   = retry_q;
    assign state_o       = state_q;

endmodule
